hs32_mem_arbiter: RTL

//  Shares the single external memory port between the instruction fetch unit and the execute
//  (load/store) unit. Accepts one request at a time, holds it on the memory bus until the memory

---
 rtl/hs32_mem_arbiter.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/hs32_mem_arbiter.sv
// hs32_mem_arbiter: shares one external memory port between instruction fetch and execute.
// Build option ARB_FAIR_EN: round-robin arbitration instead of execute-over-fetch priority.
module hs32_mem_arbiter (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] addr_f,
  input  logic        reqm_f,
  output logic [31:0] dtr_f,
  output logic        rdym_f,
  input  logic [31:0] addr_e,
  input  logic [31:0] dtw_e,
  input  logic        rw_e,
  input  logic        req_e,
  output logic [31:0] dtr_e,
  output logic        rdy_e,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_dtw,
  output logic        mem_rw,
  output logic        mem_valid,
  input  logic [31:0] mem_dtr,
  input  logic        mem_ready
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MEM_F = 2'd1,
    MEM_E = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t      state_r, state_s;
  logic [31:0] mem_addr_r, mem_addr_s;
  logic [31:0] mem_dtw_r, mem_dtw_s;
  logic        mem_rw_r, mem_rw_s;
  logic        mem_valid_r, mem_valid_s;
  logic [31:0] dtr_f_r, dtr_f_s;
  logic [31:0] dtr_e_r, dtr_e_s;
  logic        rdym_f_r, rdym_f_s;
  logic        rdy_e_r, rdy_e_s;
  logic        grant_e_s, grant_f_s;

`ifdef ARB_FAIR_EN
  logic        last_e_r, last_e_s;

  // Round-robin winner: on a tie, the requester that did not win last time
  always_comb begin
    grant_e_s = 1'b0;
    grant_f_s = 1'b0;
    if (req_e && reqm_f) begin
      grant_e_s = ~last_e_r;
      grant_f_s = last_e_r;
    end else begin
      grant_e_s = req_e;
      grant_f_s = reqm_f;
    end
  end

  // Last-grant flag follows every grant issued from IDLE
  always_comb begin
    last_e_s = last_e_r;
    if ((state_r == IDLE) && (grant_e_s || grant_f_s)) begin
      last_e_s = grant_e_s;
    end else begin
      last_e_s = last_e_r;
    end
  end

  // Last-grant register, cleared to "fetch"
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_e_r <= 1'b0;
    end else begin
      last_e_r <= last_e_s;
    end
  end
`else
  // Fixed priority winner: execute beats fetch
  always_comb begin
    grant_e_s = req_e;
    grant_f_s = reqm_f & ~req_e;
  end
`endif

  // Next-state and next-output logic; mem_* registers hold unless a new grant loads them
  always_comb begin
    state_s     = state_r;
    mem_addr_s  = mem_addr_r;
    mem_dtw_s   = mem_dtw_r;
    mem_rw_s    = mem_rw_r;
    mem_valid_s = mem_valid_r;
    dtr_f_s     = dtr_f_r;
    dtr_e_s     = dtr_e_r;
    rdym_f_s    = 1'b0;
    rdy_e_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (grant_e_s) begin
          mem_addr_s  = addr_e;
          mem_dtw_s   = dtw_e;
          mem_rw_s    = rw_e;
          mem_valid_s = 1'b1;
          state_s     = MEM_E;
        end else if (grant_f_s) begin
          mem_addr_s  = addr_f;
          mem_dtw_s   = 32'd0;
          mem_rw_s    = 1'b0;
          mem_valid_s = 1'b1;
          state_s     = MEM_F;
        end else begin
          state_s     = IDLE;
        end
      end
      MEM_F: begin
        if (mem_ready) begin
          dtr_f_s     = mem_dtr;
          rdym_f_s    = 1'b1;
          mem_valid_s = 1'b0;
          state_s     = RESP;
        end else begin
          state_s     = MEM_F;
        end
      end
      MEM_E: begin
        // A write returns zero so the execute unit never sees stale bus data
        if (mem_ready) begin
          dtr_e_s     = mem_rw_r ? 32'd0 : mem_dtr;
          rdy_e_s     = 1'b1;
          mem_valid_s = 1'b0;
          state_s     = RESP;
        end else begin
          state_s     = MEM_E;
        end
      end
      RESP: begin
        state_s = IDLE;
      end
      default: begin
        mem_valid_s = 1'b0;
        state_s     = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any transaction in flight
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r     <= IDLE;
      mem_addr_r  <= 32'd0;
      mem_dtw_r   <= 32'd0;
      mem_rw_r    <= 1'b0;
      mem_valid_r <= 1'b0;
      dtr_f_r     <= 32'd0;
      dtr_e_r     <= 32'd0;
      rdym_f_r    <= 1'b0;
      rdy_e_r     <= 1'b0;
    end else begin
      state_r     <= state_s;
      mem_addr_r  <= mem_addr_s;
      mem_dtw_r   <= mem_dtw_s;
      mem_rw_r    <= mem_rw_s;
      mem_valid_r <= mem_valid_s;
      dtr_f_r     <= dtr_f_s;
      dtr_e_r     <= dtr_e_s;
      rdym_f_r    <= rdym_f_s;
      rdy_e_r     <= rdy_e_s;
    end
  end

  assign mem_addr  = mem_addr_r;
  assign mem_dtw   = mem_dtw_r;
  assign mem_rw    = mem_rw_r;
  assign mem_valid = mem_valid_r;
  assign dtr_f     = dtr_f_r;
  assign dtr_e     = dtr_e_r;
  assign rdym_f    = rdym_f_r;
  assign rdy_e     = rdy_e_r;

endmodule
